// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard plus a control-hazard FSM
// for an in-order issue stage. Counts outstanding writes per architectural register,
// stalls issue on RAW hazards or counter saturation, and stalls after control
// instructions until they resolve (plus an optional fixed penalty).
//
// Optional feature: define HAZARD_SCOREBOARD_BYPASS_EN to let a source whose only
// pending write is retiring in this same cycle issue without a data stall.
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 2,
    parameter int CTRL_PENALTY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [REG_AW-1:0]   issue_rs1,
    input  logic [REG_AW-1:0]   issue_rs2,
    input  logic                issue_rs1_used,
    input  logic                issue_rs2_used,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic                issue_rd_we,
    input  logic                issue_is_ctrl,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                resolve_valid,
    output logic                data_stall,
    output logic                control_stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_underflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PENALTY = 2'd2
    } ctrl_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       PEN_LOAD = 4'(CTRL_PENALTY);

    logic [CNT_W-1:0] count [NUM_REGS];

    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wb_cnt;

    logic rs1_hazard;
    logic rs2_hazard;
    logic rd_saturated;
    logic do_inc;
    logic do_dec;
    logic wb_orphan;

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic [3:0]  pen_cnt;
    logic [3:0]  next_pen;

    // Look up the pending counts of every register the current cycle refers to
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        wb_cnt  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_rs1 == REG_AW'(i)) rs1_cnt = count[i];
            if (issue_rs2 == REG_AW'(i)) rs2_cnt = count[i];
            if (issue_rd  == REG_AW'(i)) rd_cnt  = count[i];
            if (wb_rd     == REG_AW'(i)) wb_cnt  = count[i];
        end
    end

    // Classify source hazards; the bypass build forgives a source whose last write retires now
    always_comb begin
        rs1_hazard = issue_rs1_used && (issue_rs1 != '0) && (rs1_cnt != '0);
        rs2_hazard = issue_rs2_used && (issue_rs2 != '0) && (rs2_cnt != '0);
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
        if (wb_valid && (wb_rd == issue_rs1) && (rs1_cnt == CNT_ONE)) rs1_hazard = 1'b0;
        if (wb_valid && (wb_rd == issue_rs2) && (rs2_cnt == CNT_ONE)) rs2_hazard = 1'b0;
`endif
    end

    // A saturated destination blocks issue unless a write to it retires in the same cycle,
    // in which case the increment and decrement cancel and the count stays at its maximum
    always_comb begin
        rd_saturated = issue_rd_we && (issue_rd != '0) && (rd_cnt == CNT_MAX)
                       && !(wb_valid && (wb_rd == issue_rd));
    end

    // Issue handshake and counter update strobes
    always_comb begin
        data_stall = issue_valid && (rs1_hazard || rs2_hazard || rd_saturated);
        issue_fire = issue_valid && !data_stall && !control_stall;
        do_inc     = issue_fire && issue_rd_we && (issue_rd != '0);
        do_dec     = wb_valid && (wb_rd != '0) && (wb_cnt != '0);
        wb_orphan  = wb_valid && (wb_rd != '0) && (wb_cnt == '0);
    end

    // Per-register pending counters and the sticky orphan-writeback flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count[i] <= '0;
            end
            wb_underflow <= 1'b0;
        end else begin
            count[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (do_inc && (issue_rd == REG_AW'(i)) && !(do_dec && (wb_rd == REG_AW'(i)))) begin
                    count[i] <= count[i] + CNT_ONE;
                end else if (do_dec && (wb_rd == REG_AW'(i)) && !(do_inc && (issue_rd == REG_AW'(i)))) begin
                    count[i] <= count[i] - CNT_ONE;
                end
            end
            if (wb_orphan) begin
                wb_underflow <= 1'b1;
            end
        end
    end

    // Busy flags mirror nonzero counts; register 0 never reports busy
    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_vec[i] = (count[i] != '0);
        end
    end

    // Control FSM state register and penalty down-counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pen_cnt <= '0;
        end else begin
            state   <= next_state;
            pen_cnt <= next_pen;
        end
    end

    // Control stall is a pure function of the FSM state, kept apart from next-state logic
    always_comb begin
        control_stall = (state == ST_WAIT) || (state == ST_PENALTY);
    end

    // Control FSM next-state: wait for resolution, then burn the configured penalty
    always_comb begin
        next_state = state;
        next_pen   = pen_cnt;
        case (state)
            ST_IDLE: begin
                if (issue_fire && issue_is_ctrl) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resolve_valid) begin
                    if (CTRL_PENALTY == 0) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_PENALTY;
                        next_pen   = PEN_LOAD;
                    end
                end
            end
            ST_PENALTY: begin
                if (pen_cnt <= 4'd1) begin
                    next_state = ST_IDLE;
                    next_pen   = '0;
                end else begin
                    next_pen = pen_cnt - 4'd1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_pen   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenario tasks plus a randomized run checked against
// a behavioural model of pending writes and control-stall duration.
module tb_hazard_scoreboard;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int PEN  = 2;
    localparam int MAXC = 3;

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic [AW-1:0] issue_rs1;
    logic [AW-1:0] issue_rs2;
    logic          issue_rs1_used;
    logic          issue_rs2_used;
    logic [AW-1:0] issue_rd;
    logic          issue_rd_we;
    logic          issue_is_ctrl;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          resolve_valid;
    logic          data_stall;
    logic          control_stall;
    logic          issue_fire;
    logic [NR-1:0] busy_vec;
    logic          wb_underflow;

    int checks;
    int failures;

    int m_cnt [NR];
    bit m_wait;
    int m_pen;
    bit m_uf;

    hazard_scoreboard #(
        .NUM_REGS    (NR),
        .REG_AW      (AW),
        .CNT_W       (CW),
        .CTRL_PENALTY(PEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rs1_used(issue_rs1_used),
        .issue_rs2_used(issue_rs2_used),
        .issue_rd      (issue_rd),
        .issue_rd_we   (issue_rd_we),
        .issue_is_ctrl (issue_is_ctrl),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .resolve_valid (resolve_valid),
        .data_stall    (data_stall),
        .control_stall (control_stall),
        .issue_fire    (issue_fire),
        .busy_vec      (busy_vec),
        .wb_underflow  (wb_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid    = 1'b0;
        issue_rs1      = '0;
        issue_rs2      = '0;
        issue_rs1_used = 1'b0;
        issue_rs2_used = 1'b0;
        issue_rd       = '0;
        issue_rd_we    = 1'b0;
        issue_is_ctrl  = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = '0;
        resolve_valid  = 1'b0;
    endtask

    task automatic set_issue(input logic [AW-1:0] r1, input logic u1, input logic [AW-1:0] r2,
                             input logic u2, input logic [AW-1:0] rd, input logic we,
                             input logic ctl);
        issue_valid    = 1'b1;
        issue_rs1      = r1;
        issue_rs1_used = u1;
        issue_rs2      = r2;
        issue_rs2_used = u2;
        issue_rd       = rd;
        issue_rd_we    = we;
        issue_is_ctrl  = ctl;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Expected data stall computed from pending-write counts held in the model
    function automatic bit model_src_blocks(input int r);
        bit blk;
        blk = (r != 0) && (m_cnt[r] > 0);
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
        if (wb_valid && (int'(wb_rd) == r) && (m_cnt[r] == 1)) blk = 0;
`endif
        return blk;
    endfunction

    function automatic bit model_data_stall();
        bit h;
        h = 0;
        if (issue_rs1_used && model_src_blocks(int'(issue_rs1))) h = 1;
        if (issue_rs2_used && model_src_blocks(int'(issue_rs2))) h = 1;
        if (issue_rd_we && issue_rd != 0 && m_cnt[issue_rd] == MAXC
            && !(wb_valid && wb_rd == issue_rd)) h = 1;
        return issue_valid && h;
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({data_stall, control_stall, issue_fire, wb_underflow} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {data_stall, control_stall, issue_fire, wb_underflow});
        end
        checks++;
        if (busy_vec !== '0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %h expected 0", busy_vec);
        end
        set_issue(0, 0, 0, 0, 4, 1, 1);
        tick();
        clear_inputs();
        wb_valid = 1'b1;
        wb_rd    = 9;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if ({control_stall, wb_underflow, busy_vec} !== {2'b00, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_midflight: got cs=%b uf=%b busy=%h expected 0 0 0",
                     control_stall, wb_underflow, busy_vec);
        end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        set_issue(0, 0, 0, 0, 5, 1, 0);
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            failures++;
            $display("[TB] FAIL raw_first_fire: got %b expected 1", issue_fire);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0020) begin
            failures++;
            $display("[TB] FAIL raw_busy5: got %h expected 00000020", busy_vec);
        end
        set_issue(5, 1, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({data_stall, issue_fire} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL raw_stall: got ds/fire=%b expected 10", {data_stall, issue_fire});
        end
        set_issue(0, 0, 5, 0, 0, 0, 0);
        #1;
        checks++;
        if ({data_stall, issue_fire} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL raw_unused_src: got ds/fire=%b expected 01", {data_stall, issue_fire});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_bypass();
        logic exp_ds;
        do_reset();
        set_issue(0, 0, 0, 0, 5, 1, 0);
        tick();
        clear_inputs();
        set_issue(5, 1, 0, 0, 0, 0, 0);
        wb_valid = 1'b1;
        wb_rd    = 5;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
        exp_ds = 1'b0;
`else
        exp_ds = 1'b1;
`endif
        #1;
        checks++;
        if ({data_stall, issue_fire} !== {exp_ds, ~exp_ds}) begin
            failures++;
            $display("[TB] FAIL bypass_same_cycle: got ds/fire=%b expected %b",
                     {data_stall, issue_fire}, {exp_ds, ~exp_ds});
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy_vec !== '0) begin
            failures++;
            $display("[TB] FAIL bypass_retired: got %h expected 0", busy_vec);
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        set_issue(0, 0, 0, 0, 0, 1, 0);
        #1;
        checks++;
        if (issue_fire !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_fire: got %b expected 1", issue_fire);
        end
        tick();
        set_issue(0, 1, 0, 1, 0, 1, 0);
        #1;
        checks++;
        if ({busy_vec, data_stall, issue_fire} !== {32'h0, 2'b01}) begin
            failures++;
            $display("[TB] FAIL zero_no_hazard: got busy=%h ds=%b fire=%b expected 0 0 1",
                     busy_vec, data_stall, issue_fire);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_control_penalty();
        do_reset();
        resolve_valid = 1'b1;
        tick();
        resolve_valid = 1'b0;
        #1;
        checks++;
        if (control_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ctrl_idle_resolve: got %b expected 0", control_stall);
        end
        set_issue(0, 0, 0, 0, 0, 0, 1);
        #1;
        checks++;
        if ({issue_fire, control_stall} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL ctrl_issue: got fire/cs=%b expected 10", {issue_fire, control_stall});
        end
        tick();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        for (int w = 1; w <= 3; w++) begin
            resolve_valid = (w == 3);
            #1;
            checks++;
            if ({control_stall, issue_fire} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL ctrl_wait%0d: got cs/fire=%b expected 10", w,
                         {control_stall, issue_fire});
            end
            tick();
        end
        resolve_valid = 1'b0;
        for (int p = 1; p <= PEN; p++) begin
            #1;
            checks++;
            if (control_stall !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ctrl_penalty%0d: got %b expected 1", p, control_stall);
            end
            tick();
        end
        #1;
        checks++;
        if ({control_stall, issue_fire} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL ctrl_release: got cs/fire=%b expected 01", {control_stall, issue_fire});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_issue(0, 0, 0, 0, 7, 1, 0);
            #1;
            checks++;
            if (issue_fire !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sat_fill%0d: got %b expected 1", k, issue_fire);
            end
            tick();
        end
        #1;
        checks++;
        if ({data_stall, issue_fire} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL sat_fourth: got ds/fire=%b expected 10", {data_stall, issue_fire});
        end
        wb_valid = 1'b1;
        wb_rd    = 7;
        #1;
        checks++;
        if ({data_stall, issue_fire} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL sat_swap: got ds/fire=%b expected 01", {data_stall, issue_fire});
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (data_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_kept3: got %b expected 1", data_stall);
        end
        clear_inputs();
        wb_valid = 1'b1;
        wb_rd    = 7;
        tick();
        tick();
        tick();
        clear_inputs();
        #1;
        checks++;
        if ({busy_vec[7], wb_underflow} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL sat_drain: got busy7/uf=%b expected 00", {busy_vec[7], wb_underflow});
        end
    endtask

    task automatic test_underflow();
        do_reset();
        set_issue(0, 0, 0, 0, 3, 1, 0);
        tick();
        clear_inputs();
        wb_valid = 1'b1;
        wb_rd    = 9;
        tick();
        clear_inputs();
        tick();
        tick();
        #1;
        checks++;
        if ({wb_underflow, busy_vec} !== {1'b1, 32'h0000_0008}) begin
            failures++;
            $display("[TB] FAIL uf_sticky: got uf=%b busy=%h expected 1 00000008",
                     wb_underflow, busy_vec);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({wb_underflow, busy_vec} !== {1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL uf_cleared: got uf=%b busy=%h expected 0 0", wb_underflow, busy_vec);
        end
    endtask

    task automatic test_random();
        bit            exp_ds;
        bit            exp_cs;
        bit            exp_fire;
        logic [NR-1:0] exp_busy;
        bit            inc;
        bit            dec_ok;
        int            cand [$];
        do_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_wait = 0;
        m_pen  = 0;
        m_uf   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rs1      = AW'($urandom_range(0, 7));
            issue_rs2      = AW'($urandom_range(0, 7));
            issue_rs1_used = $urandom_range(0, 1);
            issue_rs2_used = $urandom_range(0, 1);
            issue_rd       = AW'($urandom_range(0, 7));
            issue_rd_we    = ($urandom_range(0, 3) != 0);
            issue_is_ctrl  = ($urandom_range(0, 9) == 0);
            resolve_valid  = ($urandom_range(0, 3) == 0);
            cand.delete();
            for (int r = 1; r < NR; r++) if (m_cnt[r] > 0) cand.push_back(r);
            wb_valid = 1'b0;
            wb_rd    = '0;
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1;
                wb_rd    = AW'(cand[$urandom_range(0, cand.size() - 1)]);
            end

            exp_ds   = model_data_stall();
            exp_cs   = m_wait || (m_pen > 0);
            exp_fire = issue_valid && !exp_ds && !exp_cs;
            exp_busy = '0;
            for (int r = 1; r < NR; r++) exp_busy[r] = (m_cnt[r] > 0);
            #1;
            checks++;
            if ({data_stall, control_stall, issue_fire} !== {exp_ds, exp_cs, exp_fire}) begin
                failures++;
                $display("[TB] FAIL rand_stalls cycle %0d: got ds/cs/fire=%b expected %b", cyc,
                         {data_stall, control_stall, issue_fire}, {exp_ds, exp_cs, exp_fire});
            end
            checks++;
            if ({busy_vec, wb_underflow} !== {exp_busy, m_uf}) begin
                failures++;
                $display("[TB] FAIL rand_state cycle %0d: got busy=%h uf=%b expected %h %b", cyc,
                         busy_vec, wb_underflow, exp_busy, m_uf);
            end

            inc    = exp_fire && issue_rd_we && (issue_rd != 0);
            dec_ok = wb_valid && (wb_rd != 0) && (m_cnt[wb_rd] > 0);
            if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_uf = 1;
            if (inc) m_cnt[issue_rd]++;
            if (dec_ok) m_cnt[wb_rd]--;
            if (m_wait) begin
                if (resolve_valid) begin
                    m_wait = 0;
                    m_pen  = PEN;
                end
            end else if (m_pen > 0) begin
                m_pen--;
            end else if (exp_fire && issue_is_ctrl) begin
                m_wait = 1;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_raw_hazard();
        test_bypass();
        test_reg_zero();
        test_control_penalty();
        test_saturation();
        test_underflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter REG_AW, default 5, register address width, with 2^REG_AW >= NUM_REGS.
REQ-003 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-004 SHALL have parameter CTRL_PENALTY, default 1, extra stall cycles after a control instruction resolves (0..15).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port issue_valid, input, 1, an instruction is presented for issue.
REQ-008 SHALL have ports issue_rs1 and issue_rs2, input, REG_AW each, source registers.
REQ-009 SHALL have ports issue_rs1_used and issue_rs2_used, input, 1 each, source actually read; LUI, AUIPC and JAL drive 0.
REQ-010 SHALL have ports issue_rd, input, REG_AW, and issue_rd_we, input, 1, destination and its write enable.
REQ-011 SHALL have port issue_is_ctrl, input, 1, the instruction is JAL, JALR or BRANCH.
REQ-012 SHALL have ports wb_valid, input, 1, and wb_rd, input, REG_AW, a register write retiring this cycle.
REQ-013 SHALL have port resolve_valid, input, 1, the outstanding control instruction has resolved its target.
REQ-014 SHALL have outputs data_stall, control_stall and issue_fire, 1 bit each.
REQ-015 SHALL have output busy_vec, NUM_REGS, bit i set when register i has a nonzero pending count.
REQ-016 SHALL have output wb_underflow, 1, sticky error flag.

Function
REQ-017 SHALL keep one CNT_W-bit pending counter per register 1..NUM_REGS-1; register 0 never counts and never hazards.
REQ-018 SHALL assert data_stall combinationally when issue_valid=1 and a used, nonzero source has a nonzero count, or when issue_rd_we=1, issue_rd!=0 and count[issue_rd] equals 2^CNT_W-1 (saturation).
REQ-019 SHALL drive issue_fire = issue_valid AND NOT data_stall AND NOT control_stall.
REQ-020 SHALL increment count[issue_rd] on issue_fire with issue_rd_we=1 and issue_rd!=0.
REQ-021 SHALL decrement count[wb_rd] on wb_valid=1 with wb_rd!=0.
REQ-022 SHALL leave a count unchanged when an increment and a decrement target the same register in the same cycle.
REQ-023 SHALL ignore wb_valid to a register whose count is 0, leave that count at 0, and set wb_underflow until reset.
REQ-024 SHALL implement control FSM IDLE, WAIT, PENALTY; control_stall=1 exactly in WAIT and PENALTY.
REQ-025 SHALL move IDLE->WAIT on issue_fire with issue_is_ctrl=1; resolve_valid in IDLE is ignored.
REQ-026 SHALL, on resolve_valid in WAIT, move to IDLE if CTRL_PENALTY=0, else to PENALTY loading a down-counter with CTRL_PENALTY.
REQ-027 SHALL decrement the penalty counter each cycle in PENALTY and return to IDLE on the cycle the counter reads 1.
REQ-028 SHALL register no outputs except wb_underflow; data_stall, control_stall, issue_fire and busy_vec derive from current state and inputs.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, clear all counters, set the FSM to IDLE, clear the penalty counter and wb_underflow, regardless of in-flight activity.
REQ-030 SHALL hold data_stall=0, control_stall=0 and busy_vec=0 after reset until the first issue_fire.

Configuration
REQ-031 SHALL, when macro HAZARD_SCOREBOARD_BYPASS_EN is defined, exclude from the REQ-018 source check a register whose count is 1 and which equals wb_rd with wb_valid=1 in the same cycle; without the macro, such a source stalls.

Verification
REQ-032 Reset, then issue rd=5 we=1 -> issue_fire=1, busy_vec[5]=1 next cycle; next issue rs1=5 used -> data_stall=1.
REQ-033 count[5]=1, wb_valid wb_rd=5 with issue rs1=5 in same cycle -> data_stall=1 without the macro, 0 and issue_fire=1 with it.
REQ-034 Issue rd=0 we=1, then rs1=0 used -> busy_vec=0, data_stall=0.
REQ-035 Issue BRANCH, hold 3 cycles, resolve_valid, CTRL_PENALTY=2 -> control_stall high 3+2 cycles after issue, then 0.
REQ-036 CNT_W=2: issue rd=7 three times, no writeback -> fourth issue rd=7 gets data_stall=1; simultaneous wb_rd=7 and issue rd=7 keeps count 3.
REQ-037 wb_valid wb_rd=9 with count 0 -> wb_underflow=1 until rst_n=0, counts unchanged.
